// File: rtl/imm_encoder_pkg.sv
// Shared constants, state encoding and result payload for the immediate encoder.
package imm_encoder_pkg;

   localparam int unsigned REGISTER_LEN = 32;
   localparam int unsigned ROT_W        = 4;
   localparam int unsigned IMM_W        = 8;
   localparam int unsigned SHOP_W       = 12;
   localparam int unsigned OFFSET_W     = 12;
   localparam int unsigned ROT_SHIFT_W  = 5;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [ROT_W-1:0] ROT_LAST = 4'hF;

   typedef enum logic [1:0] {
      IMM_ENC_IDLE   = 2'd0,
      IMM_ENC_SEARCH = 2'd1,
      IMM_ENC_DONE   = 2'd2
   } imm_enc_state_e;

   typedef struct packed {
      logic              valid;
      logic              inverted;
      logic [SHOP_W-1:0] shift_operand;
   } imm_enc_result_t;

   // Rotate left by 0..31 using a doubled word so a zero shift needs no special case.
   function automatic logic [REGISTER_LEN-1:0] rol32(input logic [REGISTER_LEN-1:0] x,
                                                     input logic [ROT_SHIFT_W-1:0]  s);
      logic [2*REGISTER_LEN-1:0] d;
      d = {x, x} << s;
      return d[2*REGISTER_LEN-1:REGISTER_LEN];
   endfunction

endpackage

// File: rtl/imm_rotate_check.sv
// Tests whether a word rotated left by 2*rot fits in 8 bits.
//   word : candidate constant
//   rot  : rotate field under test
//   fits : rotated word has zero upper 24 bits
//   imm8 : low byte of the rotated word
module imm_rotate_check
   import imm_encoder_pkg::*;
(
   input  logic [REGISTER_LEN-1:0] word,
   input  logic [ROT_W-1:0]        rot,
   output logic                    fits,
   output logic [IMM_W-1:0]        imm8
);

   logic [REGISTER_LEN-1:0] rotated;

   assign rotated = rol32(word, {rot, 1'b0});
   assign fits    = (rotated[REGISTER_LEN-1:IMM_W] == '0);
   assign imm8    = rotated[IMM_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative ARM immediate encoder: finds {rot, imm8} (or ~value form) for
// data-processing operands, or checks the 12-bit offset form for memory ops.
//   clk, rst_n      : clock, async active-low reset
//   start           : request, accepted only in IDLE
//   value           : constant to encode, captured on accept
//   is_mem_command  : 1 = 12-bit offset form, 0 = rotate form
//   busy            : FSM not idle
//   done            : one-cycle pulse when the result is updated
//   valid, inverted : encoding found / encoding is of ~value
//   shift_operand   : {rot, imm8} or offset, 0 when not valid
module imm_encoder
   import imm_encoder_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [REGISTER_LEN-1:0] value,
   input  logic                    is_mem_command,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   output logic                    inverted,
   output logic [SHOP_W-1:0]       shift_operand
);

   imm_enc_state_e          state_q, state_d;
   logic [ROT_W-1:0]        rot_q, rot_d;
   logic [REGISTER_LEN-1:0] val_q, val_d;
   logic                    mem_q, mem_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   imm_enc_result_t         res_q, res_d;

   logic                    pos_fits, neg_fits;
   logic [IMM_W-1:0]        pos_imm8, neg_imm8;
   logic [REGISTER_LEN-1:0] val_inv;

   assign val_inv = ~val_q;

   // Plain and inverted candidates are checked in parallel at the same rot.
   imm_rotate_check u_check_pos (
      .word (val_q),
      .rot  (rot_q),
      .fits (pos_fits),
      .imm8 (pos_imm8)
   );

   imm_rotate_check u_check_neg (
      .word (val_inv),
      .rot  (rot_q),
      .fits (neg_fits),
      .imm8 (neg_imm8)
   );

   // Next-state and next-register values.
   always_comb begin
      state_d = state_q;
      rot_d   = rot_q;
      val_d   = val_q;
      mem_d   = mem_q;
      res_d   = res_q;

      case (state_q)
         IMM_ENC_IDLE: begin
            if (start) begin
               val_d   = value;
               mem_d   = is_mem_command;
               rot_d   = '0;
               res_d   = '0;
               state_d = IMM_ENC_SEARCH;
            end
         end

         IMM_ENC_SEARCH: begin
            if (mem_q) begin
               res_d.inverted = DISABLE;
               if (val_q[REGISTER_LEN-1:OFFSET_W] == '0) begin
                  res_d.valid         = ENABLE;
                  res_d.shift_operand = val_q[OFFSET_W-1:0];
               end else begin
                  res_d.valid         = DISABLE;
                  res_d.shift_operand = '0;
               end
               state_d = IMM_ENC_DONE;
            end else if (pos_fits) begin
               res_d.valid         = ENABLE;
               res_d.inverted      = DISABLE;
               res_d.shift_operand = {rot_q, pos_imm8};
               state_d             = IMM_ENC_DONE;
            end else if (neg_fits) begin
               res_d.valid         = ENABLE;
               res_d.inverted      = ENABLE;
               res_d.shift_operand = {rot_q, neg_imm8};
               state_d             = IMM_ENC_DONE;
            end else if (rot_q == ROT_LAST) begin
               res_d   = '0;
               state_d = IMM_ENC_DONE;
            end else begin
               rot_d = rot_q + ROT_W'(1);
            end
         end

         IMM_ENC_DONE: begin
            state_d = IMM_ENC_IDLE;
         end

         default: begin
            state_d = IMM_ENC_IDLE;
         end
      endcase

      busy_d = (state_d != IMM_ENC_IDLE);
      done_d = (state_d == IMM_ENC_DONE);
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IMM_ENC_IDLE;
         rot_q   <= '0;
         val_q   <= '0;
         mem_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rot_q   <= rot_d;
         val_q   <= val_d;
         mem_q   <= mem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign valid         = res_q.valid;
   assign inverted      = res_q.inverted;
   assign shift_operand = res_q.shift_operand;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes model results, monitor checks on done.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] value;
   logic        is_mem_command;
   logic        busy, done, valid, inverted;
   logic [11:0] shift_operand;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [31:0] v;
      logic        mem;
      logic        valid;
      logic        inv;
      logic [11:0] so;
      int unsigned lat;
      int unsigned t0;
   } exp_t;

   exp_t sb[$];

   imm_encoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .value          (value),
      .is_mem_command (is_mem_command),
      .busy           (busy),
      .done           (done),
      .valid          (valid),
      .inverted       (inverted),
      .shift_operand  (shift_operand)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rol(input logic [31:0] x, input int s);
      int k;
      k = s % 32;
      if (k == 0) return x;
      return (x << k) | (x >> (32 - k));
   endfunction

   function automatic logic [31:0] ror(input logic [31:0] x, input int s);
      return rol(x, (32 - (s % 32)) % 32);
   endfunction

   // Reference: smallest rotate wins, plain before inverted; memory = 12-bit offset.
   function automatic exp_t model(input logic [31:0] v, input logic mem, input int unsigned t0);
      exp_t        e;
      logic [31:0] a;
      e.v = v; e.mem = mem; e.t0 = t0;
      e.valid = 1'b0; e.inv = 1'b0; e.so = 12'h000; e.lat = 17;
      if (mem) begin
         e.lat = 2;
         if (v < 32'd4096) begin
            e.valid = 1'b1;
            e.so    = v[11:0];
         end
         return e;
      end
      for (int r = 0; r < 16; r++) begin
         a = rol(v, 2 * r);
         if (a < 32'd256) begin
            e.valid = 1'b1; e.so = {4'(r), a[7:0]}; e.lat = 32'(r + 2);
            return e;
         end
         a = rol(~v, 2 * r);
         if (a < 32'd256) begin
            e.valid = 1'b1; e.inv = 1'b1; e.so = {4'(r), a[7:0]}; e.lat = 32'(r + 2);
            return e;
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare each done pulse against the oldest expectation, then check hold.
   initial begin
      exp_t        e;
      logic [31:0] rt;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
               e = sb.pop_front();
               chk("valid", 32'(valid), 32'(e.valid));
               chk("inverted", 32'(inverted), 32'(e.inv));
               chk("shift_operand", 32'(shift_operand), 32'(e.so));
               chk("latency", cyc - e.t0, e.lat);
               chk("busy_in_done", 32'(busy), 32'd1);
               if (!e.mem && valid) begin
                  rt = ror({24'b0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
                  chk("roundtrip", rt, inverted ? ~e.v : e.v);
               end
               @(negedge clk);
               if (rst_n) begin
                  chk("hold_done_low", 32'(done), 32'd0);
                  chk("hold_busy_low", 32'(busy), 32'd0);
                  chk("hold_valid", 32'(valid), 32'(e.valid));
                  chk("hold_shift_operand", 32'(shift_operand), 32'(e.so));
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
      end
   endtask

   // Issue one request; optionally toggle start and inputs while busy.
   task automatic run(input logic [31:0] v, input logic mem, input bit noise);
      int n;
      wait_idle();
      value = v;
      is_mem_command = mem;
      start = 1'b1;
      sb.push_back(model(v, mem, cyc));
      @(negedge clk);
      start = 1'b0;
      value = $urandom;
      is_mem_command = 1'($urandom);
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            value = $urandom;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 40 cycles");
         sb.delete();
      end
   endtask

   initial begin
      logic [31:0] v;
      logic        mem;
      rst_n = 1'b0;
      start = 1'b0;
      value = '0;
      is_mem_command = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_inverted", 32'(inverted), 32'd0);
      chk("rst_shift_operand", 32'(shift_operand), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(32'h0000_00FF, 1'b0, 1'b0);
      run(32'hFF00_0000, 1'b0, 1'b0);
      run(32'h0000_0104, 1'b0, 1'b0);
      run(32'hFFFF_FF00, 1'b0, 1'b0);
      run(32'h0000_0101, 1'b0, 1'b1);
      run(32'h0000_0ABC, 1'b1, 1'b0);
      run(32'h0000_1000, 1'b1, 1'b1);
      run(32'h0000_0FFF, 1'b1, 1'b0);

      // Reset while SEARCH is testing rot = 5.
      wait_idle();
      value = 32'h0000_0101;
      is_mem_command = 1'b0;
      start = 1'b1;
      sb.push_back(model(value, 1'b0, cyc));
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_busy_before_reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_inverted", 32'(inverted), 32'd0);
      chk("mid_rst_shift_operand", 32'(shift_operand), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(32'hFF00_0000, 1'b0, 1'b0);

      for (int i = 0; i < 2500; i++) begin
         case ($urandom_range(0, 4))
            0: begin v = $urandom; mem = 1'b0; end
            1: begin v = ror({24'b0, 8'($urandom)}, 2 * int'($urandom_range(0, 15))); mem = 1'b0; end
            2: begin v = ~ror({24'b0, 8'($urandom)}, 2 * int'($urandom_range(0, 15))); mem = 1'b0; end
            3: begin v = $urandom_range(0, 8191); mem = 1'b1; end
            default: begin v = $urandom; mem = 1'b1; end
         endcase
         run(v, mem, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
